// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between instruction fetch
// and the load/store stage; aligns stores to byte strobes and loads to lane 0.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             last_grant;
  logic             owner;
  logic             cap_we;
  logic [31:0]      cap_addr;
  logic [1:0]       cap_size;
  logic [31:0]      cap_wdata;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  logic [CNT_W-1:0] cnt;

  logic             grant_if;
  logic             grant_d;
  logic             misaligned;
  logic             expired;
  logic [3:0]       strobe;
  logic [31:0]      load_shifted;
  logic [31:0]      load_data;

  // Grants are only offered from IDLE; on a conflict the port that did not
  // win last time goes first.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state == S_IDLE && !rst) begin
      if (if_req && d_req) begin
        grant_d  = (last_grant == PORT_IF);
        grant_if = !grant_d;
      end else begin
        grant_if = if_req;
        grant_d  = d_req;
      end
    end
  end

  assign if_gnt = grant_if;
  assign d_gnt  = grant_d;

  // Alignment of the request being granted; fetches are always word reads.
  always_comb begin
    misaligned = 1'b0;
    if (grant_d) begin
      case (d_size)
        2'd0:    misaligned = 1'b0;
        2'd1:    misaligned = d_addr[0];
        2'd2:    misaligned = |d_addr[1:0];
        default: misaligned = 1'b1;
      endcase
    end else begin
      misaligned = |if_addr[1:0];
    end
  end

  // A late mem_gnt can push the count past the last value, so compare with >=.
  assign expired = (cnt >= CNT_LAST);

  assign load_shifted = mem_rdata >> {cap_addr[1:0], 3'b000};

  always_comb begin
    load_data = load_shifted;
    strobe    = 4'b1111;
    case (cap_size)
      2'd0: begin
        load_data = {24'h0, load_shifted[7:0]};
        strobe    = 4'b0001 << cap_addr[1:0];
      end
      2'd1: begin
        load_data = {16'h0, load_shifted[15:0]};
        strobe    = 4'b0011 << cap_addr[1:0];
      end
      default: begin
        load_data = load_shifted;
        strobe    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= PORT_IF;
      owner      <= PORT_IF;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_size   <= '0;
      cap_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_if || grant_d) begin
            owner      <= grant_d;
            last_grant <= grant_d;
            cap_we     <= grant_d & d_we;
            cap_addr   <= grant_d ? d_addr  : if_addr;
            cap_size   <= grant_d ? d_size  : 2'd2;
            cap_wdata  <= grant_d ? d_wdata : 32'h0;
            cnt        <= '0;
            if (misaligned) begin
              state      <= S_RESP;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_gnt) begin
            state <= S_WAIT;
          end else if (expired) begin
            state      <= S_RESP;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A response arriving on the expiry cycle still counts as good.
          if (mem_rvalid) begin
            state      <= S_RESP;
            resp_err   <= 1'b0;
            resp_rdata <= cap_we ? 32'h0 : load_data;
          end else if (expired) begin
            state      <= S_RESP;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = (state == S_ISSUE);
  assign mem_we    = mem_req & cap_we;
  assign mem_addr  = mem_req ? {cap_addr[31:2], 2'b00} : 32'h0;
  assign mem_wstrb = mem_req ? strobe : 4'h0;
  assign mem_wdata = mem_req ? (cap_wdata << {cap_addr[1:0], 3'b000}) : 32'h0;

  assign if_rvalid = (state == S_RESP) && (owner == PORT_IF);
  assign d_rvalid  = (state == S_RESP) && (owner == PORT_D);
  assign if_rdata  = if_rvalid ? resp_rdata : 32'h0;
  assign d_rdata   = d_rvalid  ? resp_rdata : 32'h0;
  assign if_err    = if_rvalid & resp_err;
  assign d_err     = d_rvalid  & resp_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand sequences,
// with a memory model and response scoreboard stepped once per clock.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.TIMEOUT(8), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;   // 0 = IF, 1 = D
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    bit          mem_acc;
    logic [31:0] maddr;
    logic [3:0]  mstrb;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } vec_t;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } mexp_t;

  resp_t resp_q[$];
  mexp_t mem_q[$];

  int          total = 0;
  int          bad   = 0;
  string       cur_tag = "init";
  logic [31:0] mem_word = 32'h0;
  bit          mem_hang = 1'b0;
  int          stray_cnt = 0;
  bit          rv_pend = 1'b0;
  logic [31:0] rv_data = 32'h0;

  logic [139:0] all_outs;
  assign all_outs = {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
                     mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL [%s] %s: got=%0h want=%0h (cycle %0d)", cur_tag, name, got, exp, cyc);
    end
  endtask

  // Memory model: grants any request at once, answers one cycle later unless hung.
  task automatic mem_step();
    mexp_t m;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    if (rst) begin
      rv_pend = 1'b0;
      return;
    end
    if (rv_pend) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rv_data;
      rv_pend    = 1'b0;
    end else if (stray_cnt != 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      stray_cnt--;
    end
    if (mem_req) begin
      mem_gnt = 1'b1;
      check("mem_expected", mem_q.size() != 0, 1);
      if (mem_q.size() != 0) begin
        m = mem_q.pop_front();
        check("mem_we",    mem_we,    m.we);
        check("mem_addr",  mem_addr,  m.addr);
        check("mem_wstrb", mem_wstrb, m.strb);
        check("mem_wdata", mem_wdata, m.wdata);
      end
      if (!mem_hang) begin
        rv_pend = 1'b1;
        rv_data = mem_word;
      end
    end
  endtask

  task automatic resp_step();
    resp_t e;
    if (rst || !(if_rvalid || d_rvalid)) return;
    check("resp_expected", resp_q.size() != 0, 1);
    if (resp_q.size() == 0) return;
    e = resp_q.pop_front();
    check("resp_port",  {if_rvalid, d_rvalid}, e.port ? 2'b01 : 2'b10);
    check("resp_rdata", e.port ? d_rdata : if_rdata, e.rdata);
    check("resp_err",   e.port ? d_err : if_err, e.err);
    check("resp_cycle", cyc, e.cyc);
  endtask

  // One clock: move to the falling edge, then step the model and scoreboard.
  task automatic tick();
    @(negedge clk);
    mem_step();
    resp_step();
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (if_gnt || d_gnt) begin
        ok = 1'b1;
        break;
      end
      tick();
      #1;
    end
    check("gnt_wait", ok, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (resp_q.size() == 0) break;
      tick();
    end
    check("resp_drain", resp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    bit    ok;
    mexp_t m;
    resp_t r;
    tick();
    mem_word = v.mrdata;
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_size = v.size; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    wait_gnt(ok);
    if (ok) begin
      check("gnt_port", {if_gnt, d_gnt}, v.port ? 2'b01 : 2'b10);
      if (v.mem_acc) begin
        m = '{v.we, v.maddr, v.mstrb, v.mwdata};
        mem_q.push_back(m);
      end
      r = '{v.port, v.rdata, v.err, cyc + v.lat};
      resp_q.push_back(r);
    end
    tick();
    if_req = 1'b0;
    d_req  = 1'b0;
    drain();
  endtask

  vec_t  vecs[12];
  bit    ok;
  int    n;
  mexp_t me;
  resp_t re;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //        port we addr          sz    wdata         mrdata        acc maddr         strb     mwdata        rdata         err lat
    vecs[0]  = '{0, 0, 32'h0000_0100, 2'd2, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0, 3};
    vecs[1]  = '{1, 1, 32'h0000_0203, 2'd0, 32'h0000_00A5, 32'h1234_5678, 1, 32'h0000_0200, 4'b1000, 32'hA500_0000, 32'h0,        0, 3};
    vecs[2]  = '{1, 0, 32'h0000_0302, 2'd1, 32'h0,        32'h8765_4321, 1, 32'h0000_0300, 4'b1100, 32'h0,        32'h0000_8765, 0, 3};
    vecs[3]  = '{1, 0, 32'h0000_0401, 2'd2, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1};
    vecs[4]  = '{1, 0, 32'h0000_0400, 2'd3, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1};
    vecs[5]  = '{1, 0, 32'h0000_0101, 2'd0, 32'h0,        32'h1122_3344, 1, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000_0033, 0, 3};
    vecs[6]  = '{1, 1, 32'h0000_0040, 2'd2, 32'hCAFE_F00D, 32'h5555_5555, 1, 32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 3};
    vecs[7]  = '{1, 1, 32'h0000_0102, 2'd1, 32'h0000_BEEF, 32'h0,        1, 32'h0000_0100, 4'b1100, 32'hBEEF_0000, 32'h0,        0, 3};
    vecs[8]  = '{0, 0, 32'h0000_0102, 2'd2, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1};
    vecs[9]  = '{1, 0, 32'h0000_0303, 2'd1, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1};
    vecs[10] = '{1, 0, 32'h0000_0103, 2'd0, 32'h0,        32'hAB00_0000, 1, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_00AB, 0, 3};
    vecs[11] = '{1, 0, 32'h0000_0300, 2'd1, 32'h0,        32'h8765_4321, 1, 32'h0000_0300, 4'b0011, 32'h0,        32'h0000_4321, 0, 3};

    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_size = 2'd0; d_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    cur_tag = "reset";
    repeat (3) tick();
    check("reset_outputs_zero", |all_outs, 0);
    rst = 1'b0;

    // Both ports request continuously: D must win first, then strict alternation.
    cur_tag = "alternate";
    tick();
    mem_word = 32'h0BAD_F00D;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500; d_size = 2'd2; d_wdata = 32'h0;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(ok);
      if (!ok) break;
      check("alt_winner", {if_gnt, d_gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
      me = '{1'b0, d_gnt ? 32'h0000_0500 : 32'h0000_0200, 4'b1111, 32'h0};
      mem_q.push_back(me);
      re = '{d_gnt, 32'h0BAD_F00D, 1'b0, cyc + 3};
      resp_q.push_back(re);
      tick();
      #1;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    drain();

    for (int i = 0; i < 12; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    // Memory grants but never answers: error exactly 8 cycles after ISSUE.
    cur_tag = "timeout";
    mem_hang = 1'b1;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600; d_size = 2'd2; d_wdata = 32'h0;
    #1;
    wait_gnt(ok);
    n = cyc;
    if (ok) begin
      me = '{1'b0, 32'h0000_0600, 4'b1111, 32'h0};
      mem_q.push_back(me);
      re = '{1'b1, 32'h0, 1'b1, n + 9};
      resp_q.push_back(re);
    end
    tick();
    d_req = 1'b0;
    tick();
    check("wait_mem_req_low", mem_req, 0);
    drain();
    mem_hang = 1'b0;
    cur_tag = "stray";
    stray_cnt = 1;
    repeat (5) tick();
    check("stray_delivered", stray_cnt, 0);

    // Reset while waiting on memory: everything returns to zero, no response.
    cur_tag = "reset_in_wait";
    mem_hang = 1'b1;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0700; d_size = 2'd2;
    #1;
    wait_gnt(ok);
    if (ok) begin
      me = '{1'b0, 32'h0000_0700, 4'b1111, 32'h0};
      mem_q.push_back(me);
    end
    tick();
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_wait_outputs_zero", |all_outs, 0);
    rst = 1'b0;
    mem_hang = 1'b0;
    repeat (6) tick();

    cur_tag = "recover";
    vecs[0].addr   = 32'h0000_0104;
    vecs[0].maddr  = 32'h0000_0104;
    vecs[0].mrdata = 32'h5A5A_1234;
    vecs[0].rdata  = 32'h5A5A_1234;
    run_vec(vecs[0]);

    repeat (4) tick();
    cur_tag = "end";
    check("resp_queue_empty", resp_q.size(), 0);
    check("mem_queue_empty",  mem_q.size(),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
